// File: rtl/gun_hit_ctrl.sv
// Light-gun shot sequencer: synchronises trigger/photodiode, shows the target
// overlay for FLASH_FRAMES active frames, counts lit photodiode samples in the
// active area and reports a one-cycle hit or miss verdict, then holds off
// further shots for COOLDOWN_FRAMES frames.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a trigger press
// ARM      | trigger seen, waiting for start of blanking
// FLASH    | overlay shown, counting lit samples in active video
// EVAL     | verdict cycle (hit or miss pulse visible)
// COOLDOWN | triggers ignored until COOLDOWN_FRAMES frame edges pass
module gun_hit_ctrl #(
  parameter int unsigned FLASH_FRAMES    = 1,
  parameter int unsigned HIT_THRESHOLD   = 64,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  input  logic trigger,
  input  logic photodiode,
  input  logic calibration,
  output logic overlay_en,
  output logic hit,
  output logic miss,
  output logic busy
);

  localparam int unsigned FC_MAX = (FLASH_FRAMES > COOLDOWN_FRAMES) ? FLASH_FRAMES : COOLDOWN_FRAMES;
  localparam int FCW = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_FRAMES - 1);
  localparam logic [FCW-1:0] COOL_LAST  = FCW'(COOLDOWN_FRAMES - 1);
  localparam logic [19:0]    THRESH     = 20'(HIT_THRESHOLD);
  localparam logic [19:0]    LIGHT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FLASH,
    S_EVAL,
    S_COOLDOWN
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [FCW-1:0] frame_cnt;
  logic [19:0]    light_cnt;

  logic trig_m, trig_s, trig_q;
  logic photo_m, photo_s;
  logic vblnk_q;
  logic trig_rise;
  logic vb_rise;

  // Two-flop synchronisers for the gun inputs plus edge-detect delay flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_m  <= 1'b0;
      trig_s  <= 1'b0;
      trig_q  <= 1'b0;
      photo_m <= 1'b0;
      photo_s <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      trig_m  <= trigger;
      trig_s  <= trig_m;
      trig_q  <= trig_s;
      photo_m <= photodiode;
      photo_s <= photo_m;
      vblnk_q <= vblnk;
    end
  end

  assign trig_rise = trig_s & ~trig_q;
  assign vb_rise   = vblnk & ~vblnk_q;

  // Next-state decode; calibration overrides everything and parks in IDLE.
  always_comb begin
    state_nxt = state;
    if (calibration) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (trig_rise) state_nxt = S_ARM;
        S_ARM:      if (vb_rise) state_nxt = S_FLASH;
        S_FLASH:    if (vb_rise && frame_cnt == FLASH_LAST) state_nxt = S_EVAL;
        S_EVAL:     state_nxt = S_COOLDOWN;
        S_COOLDOWN: if (vb_rise && frame_cnt == COOL_LAST) state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // State register, frame/light counters and registered outputs; the verdict
  // is registered on the final frame edge so it is visible during EVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      frame_cnt  <= '0;
      light_cnt  <= '0;
      overlay_en <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      overlay_en <= (state_nxt == S_FLASH) | calibration;
      busy       <= (state_nxt != S_IDLE);
      hit        <= 1'b0;
      miss       <= 1'b0;
      if (calibration) begin
        frame_cnt <= '0;
        light_cnt <= '0;
      end else begin
        case (state)
          S_ARM: begin
            if (vb_rise) begin
              frame_cnt <= '0;
              light_cnt <= '0;
            end
          end
          S_FLASH: begin
            if (photo_s && !vblnk && light_cnt != LIGHT_MAX) light_cnt <= light_cnt + 20'd1;
            if (vb_rise) begin
              if (frame_cnt == FLASH_LAST) begin
                hit  <= (light_cnt >= THRESH);
                miss <= (light_cnt < THRESH);
              end else begin
                frame_cnt <= frame_cnt + FCW'(1);
              end
            end
          end
          S_EVAL: frame_cnt <= '0;
          S_COOLDOWN: begin
            if (vb_rise) begin
              if (frame_cnt == COOL_LAST) frame_cnt <= '0;
              else frame_cnt <= frame_cnt + FCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gun_hit_ctrl.sv
// Bench for gun_hit_ctrl: two instances (1-frame and 3-frame flash) share one
// frame-structured stimulus stream. A frame-level shot model pushes expected
// verdicts into per-instance queues; a monitor pops them on hit/miss pulses.
module tb_gun_hit_ctrl;
  localparam int A   = 150;
  localparam int B   = 40;
  localparam int FL  = A + B;
  localparam int N0  = 1;
  localparam int N1  = 3;
  localparam int CD  = 8;
  localparam int THR = 64;
  localparam int NFR = 140;

  logic clk = 1'b0;
  logic rst, vblnk, trigger, photodiode, calibration;
  logic ov0, hit0, miss0, busy0;
  logic ov1, hit1, miss1, busy1;

  always #5 clk = ~clk;

  gun_hit_ctrl #(.FLASH_FRAMES(N0), .HIT_THRESHOLD(THR), .COOLDOWN_FRAMES(CD)) dut0 (
    .clk(clk), .rst(rst), .vblnk(vblnk), .trigger(trigger), .photodiode(photodiode),
    .calibration(calibration), .overlay_en(ov0), .hit(hit0), .miss(miss0), .busy(busy0)
  );

  gun_hit_ctrl #(.FLASH_FRAMES(N1), .HIT_THRESHOLD(THR), .COOLDOWN_FRAMES(CD)) dut1 (
    .clk(clk), .rst(rst), .vblnk(vblnk), .trigger(trigger), .photodiode(photodiode),
    .calibration(calibration), .overlay_en(ov1), .hit(hit1), .miss(miss1), .busy(busy1)
  );

  typedef struct {
    bit is_hit;
    int frame;
  } verdict_t;

  verdict_t sbq0[$];
  verdict_t sbq1[$];

  // per-frame plan: trigger type (0 none, 1 clean, 2 bouncy), lit active
  // cycles, lit blanking cycles, calibration mode (0 none, 1 early, 2 mid), reset
  int p_trig[NFR];
  int p_lit[NFR];
  int p_blit[NFR];
  int p_mode[NFR];
  bit p_rst[NFR];

  bit e_busy[2][NFR];
  bit e_ov[2][NFR];
  bit live[2];
  int live_k[2];
  int live_a[2];

  int n_checks = 0;
  int n_pass   = 0;
  int cur_frame = -1;
  int cur_pos   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (frame %0d pos %0d)", name, act, exp, cur_frame, cur_pos);
  endfunction

  function automatic int nflash(int d);
    return (d == 0) ? N0 : N1;
  endfunction

  // Shot model at frame granularity: a shot accepted in frame k flashes frames
  // k+1..k+n, gives its verdict at the blanking start of frame k+n, and keeps
  // the block busy through frame k+n+CD unless calibration/reset cuts it short.
  task automatic model_frame(int g);
    for (int d = 0; d < 2; d++) begin
      int  n = nflash(d);
      bit  idle;
      idle = !live[d] || (g > live_k[d] + n + CD) || (g > live_a[d]);
      if (p_trig[g] != 0 && p_mode[g] != 1 && idle) begin
        live[d]   = 1'b1;
        live_k[d] = g;
        live_a[d] = 1 << 30;
        for (int h = g; h <= g + n + CD && h < NFR; h++) begin
          if (p_mode[h] != 0 || p_rst[h]) begin
            live_a[d] = h;
            break;
          end
        end
        if (live_a[d] > g + n && g + n < NFR) begin
          int sum = 0;
          verdict_t v;
          for (int h = g + 1; h <= g + n; h++) sum += p_lit[h];
          v.is_hit = (sum >= THR);
          v.frame  = g + n;
          if (d == 0) sbq0.push_back(v);
          else sbq1.push_back(v);
        end
      end
      e_busy[d][g] = live[d] && g >= live_k[d] && g <= live_k[d] + n + CD && g < live_a[d];
      e_ov[d][g]   = e_busy[d][g] && g >= live_k[d] + 1 && g <= live_k[d] + n;
    end
  endtask

  task automatic drive_frame(int g);
    model_frame(g);
    for (int p = 0; p < FL; p++) begin
      @(negedge clk);
      cur_frame = g;
      cur_pos   = p;
      vblnk     = (p >= A);
      if (p_trig[g] == 1) trigger = (p >= 2 && p <= 5);
      else if (p_trig[g] == 2) trigger = (p >= 2 && p <= 3) || (p >= 6 && p <= 7) || (p >= 10 && p <= 11);
      else trigger = 1'b0;
      photodiode  = (p >= 10 && p < 10 + p_lit[g]) || (p >= A + 5 && p < A + 5 + p_blit[g]);
      calibration = (p_mode[g] == 1 && p <= 30) || (p_mode[g] == 2 && p >= 40 && p <= 59);
      rst         = p_rst[g] && (p == 60);
    end
  endtask

  task automatic mon_dut(int d, logic h, logic m, logic ov, logic b);
    if (h || m) begin
      int qs;
      check($sformatf("hit_miss_exclusive%0d", d), int'(h && m), 0);
      qs = (d == 0) ? sbq0.size() : sbq1.size();
      check($sformatf("verdict_expected%0d", d), int'(qs > 0), 1);
      if (qs > 0) begin
        verdict_t e;
        e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
        check($sformatf("verdict_hit%0d", d), int'(h), int'(e.is_hit));
        check($sformatf("verdict_frame%0d", d), cur_frame, e.frame);
        check($sformatf("verdict_pos%0d", d), cur_pos, A);
      end
    end
    if (cur_pos == 75) begin
      check($sformatf("overlay_mid%0d", d), int'(ov), int'(e_ov[d][cur_frame]));
      check($sformatf("busy_mid%0d", d), int'(b), int'(e_busy[d][cur_frame]));
    end
    if (cur_pos == 50 && p_mode[cur_frame] == 2)
      check($sformatf("overlay_calib%0d", d), int'(ov), 1);
    if (cur_pos == 60 && p_rst[cur_frame]) begin
      check($sformatf("overlay_rst%0d", d), int'(ov), 0);
      check($sformatf("busy_rst%0d", d), int'(b), 0);
      check($sformatf("verdict_rst%0d", d), int'(h | m), 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cur_frame >= 0) begin
        mon_dut(0, hit0, miss0, ov0, busy0);
        mon_dut(1, hit1, miss1, ov1, busy1);
      end
    end
  end

  initial begin
    for (int g = 0; g < NFR; g++) begin
      p_trig[g] = 0; p_lit[g] = 0; p_blit[g] = 0; p_mode[g] = 0; p_rst[g] = 1'b0;
    end
    p_trig[1] = 1;  p_lit[2] = 100;
    p_trig[5] = 1;
    p_trig[11] = 1; p_lit[12] = 63;
    p_trig[13] = 1; p_lit[14] = 30; p_lit[15] = 30; p_lit[16] = 30;
    p_trig[25] = 1; p_lit[26] = 64;
    p_trig[37] = 1; p_blit[38] = 30; p_blit[39] = 30; p_blit[40] = 30;
    p_trig[49] = 2; p_lit[50] = 80;
    p_mode[51] = 2;
    p_mode[52] = 1; p_trig[52] = 1;
    p_trig[53] = 1;
    p_rst[54] = 1'b1; p_lit[54] = 100;
    p_trig[55] = 1; p_lit[56] = 100;
    for (int g = 59; g < NFR; g++) begin
      int r;
      r = $urandom_range(0, 99);
      if (g < NFR - 15) p_trig[g] = (r < 30) ? ((r < 8) ? 2 : 1) : 0;
      case ($urandom_range(0, 5))
        0: p_lit[g] = 0;
        1: p_lit[g] = 63;
        2: p_lit[g] = 64;
        3: p_lit[g] = 100;
        4: p_lit[g] = $urandom_range(0, 130);
        default: p_lit[g] = 30;
      endcase
      p_blit[g] = $urandom_range(0, 30);
      r = $urandom_range(0, 99);
      if (g < NFR - 15) p_mode[g] = (r < 5) ? 1 : ((r < 10) ? 2 : 0);
    end
    for (int d = 0; d < 2; d++) begin
      live[d] = 1'b0; live_k[d] = 0; live_a[d] = 0;
    end

    rst = 1'b1; vblnk = 1'b0; trigger = 1'b0; photodiode = 1'b0; calibration = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("reset_overlay0", int'(ov0), 0);
    check("reset_hit0", int'(hit0), 0);
    check("reset_miss0", int'(miss0), 0);
    check("reset_busy0", int'(busy0), 0);
    check("reset_overlay1", int'(ov1), 0);
    check("reset_hit1", int'(hit1), 0);
    check("reset_miss1", int'(miss1), 0);
    check("reset_busy1", int'(busy1), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int g = 0; g < NFR; g++) drive_frame(g);

    @(posedge clk);
    #3;
    check("pending_verdicts0", sbq0.size(), 0);
    check("pending_verdicts1", sbq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
